controller_hub: RTL and testbench

- Next-generation game-controller front end. Replaces the fixed 2-pad, 8-button NES interface.
- Scans NUM_CONTROLLERS serial pads (NES or SNES style, BUTTONS bits each) when it receives a fetch pulse from the GPU vblank logic.
- Holds per-pad live state and sticky "pressed since last read" edge registers, and exposes them as a byte-wide memory-mapped register file to the CPU address decode.

---
 rtl/controller_hub_pkg.sv | 28 ++
 rtl/controller_hub_timing.sv | 127 ++++++++++++
 rtl/controller_hub.sv | 148 ++++++++++++++
 tb/tb_controller_hub.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/controller_hub_pkg.sv
// Shared types for the mapache64 controller front end: register map
// encoding, register stride and the button vector type.
package mapache64;

    // Each pad occupies one 8-byte window in the register file.
    localparam int CONTROLLER_REG_STRIDE = 8;

    // Widest pad supported; narrower pads leave the upper bits at 0.
    typedef logic [15:0] controller_buttons_t;

    typedef enum logic [2:0] {
        STATE_LO    = 3'd0,
        STATE_HI    = 3'd1,
        PRESSED_LO  = 3'd2,
        PRESSED_HI  = 3'd3,
        RELEASED_LO = 3'd4,
        RELEASED_HI = 3'd5
    } controller_reg_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_LOW,
        ST_HIGH,
        ST_COMMIT
    } hub_state_e;

endpackage

// File: rtl/controller_hub_timing.sv
// Scan sequencer for the serial pads: latch pulse, shift clock, bit index
// and the strobes telling the parent when to sample pad data and commit.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  ST_IDLE   | waiting for start_fetch; shift clock high, latch low
//  ST_LATCH  | latch high for LATCH_PULSE_WIDTH cycles; bit 0 sampled at exit
//  ST_LOW    | shift clock low for CLK_DIV cycles
//  ST_HIGH   | shift clock high for CLK_DIV cycles; next bit sampled at exit
//  ST_COMMIT | one cycle; parent commits shift data, valid asserted
module controller_hub_timing
    import mapache64::*;
#(
    parameter int BUTTONS           = 8,
    parameter int LATCH_PULSE_WIDTH = 2,
    parameter int CLK_DIV           = 4,
    localparam int BIT_W            = (BUTTONS > 1) ? $clog2(BUTTONS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_fetch,
    output logic             busy,
    output logic             valid,
    output logic             pad_clk,
    output logic             pad_latch,
    output logic             sample,
    output logic [BIT_W-1:0] sample_idx
);

    localparam int CNT_MAX = (LATCH_PULSE_WIDTH > CLK_DIV) ? LATCH_PULSE_WIDTH : CLK_DIV;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] LATCH_LOAD = CNT_W'(LATCH_PULSE_WIDTH - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD   = CNT_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(BUTTONS - 1);

    hub_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [BIT_W-1:0] bit_q;
    logic             cnt_done;

    assign cnt_done = (cnt_q == '0);

    // Sample strobes fire on the last cycle of LATCH and of every HIGH but the final one.
    always_comb begin
        sample     = 1'b0;
        sample_idx = '0;
        if (state_q == ST_LATCH && cnt_done) begin
            sample = 1'b1;
        end else if (state_q == ST_HIGH && cnt_done && bit_q != BIT_LAST) begin
            sample     = 1'b1;
            sample_idx = bit_q + BIT_W'(1);
        end
    end

    // Scan FSM with down-counting phase timer and registered pad outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            busy      <= 1'b0;
            valid     <= 1'b0;
            pad_clk   <= 1'b1;
            pad_latch <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_fetch) begin
                        state_q   <= ST_LATCH;
                        busy      <= 1'b1;
                        pad_latch <= 1'b1;
                        cnt_q     <= LATCH_LOAD;
                    end
                end
                ST_LATCH: begin
                    if (cnt_done) begin
                        state_q   <= ST_LOW;
                        pad_latch <= 1'b0;
                        pad_clk   <= 1'b0;
                        cnt_q     <= DIV_LOAD;
                        bit_q     <= '0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_LOW: begin
                    if (cnt_done) begin
                        state_q <= ST_HIGH;
                        pad_clk <= 1'b1;
                        cnt_q   <= DIV_LOAD;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_HIGH: begin
                    if (cnt_done) begin
                        if (bit_q == BIT_LAST) begin
                            state_q <= ST_COMMIT;
                            valid   <= 1'b1;
                        end else begin
                            state_q <= ST_LOW;
                            bit_q   <= bit_q + BIT_W'(1);
                            pad_clk <= 1'b0;
                            cnt_q   <= DIV_LOAD;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_COMMIT: begin
                    state_q <= ST_IDLE;
                    busy    <= 1'b0;
                    valid   <= 1'b0;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    busy      <= 1'b0;
                    valid     <= 1'b0;
                    pad_clk   <= 1'b1;
                    pad_latch <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/controller_hub.sv
// Game-controller front end: scans NUM_CONTROLLERS serial pads on request,
// keeps live STATE and sticky PRESSED bits per pad, and exposes them as a
// byte-wide register file (pad*8 + reg). Define CONTROLLER_HUB_RELEASED_EN
// to add sticky RELEASED bits at regs 4/5; otherwise those read 0x00.
module controller_hub
    import mapache64::*;
#(
    parameter int NUM_CONTROLLERS   = 2,
    parameter int BUTTONS           = 8,
    parameter int LATCH_PULSE_WIDTH = 2,
    parameter int CLK_DIV           = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start_fetch_i,
    output logic                               busy_o,
    output logic                               valid_o,
    output logic                               controller_clk_o,
    output logic                               controller_latch_o,
    input  logic [NUM_CONTROLLERS-1:0]         controller_serial_ni,
    input  logic                               sel_i,
    input  logic                               rd_i,
    input  logic [$clog2(NUM_CONTROLLERS)+2:0] addr_i,
    output logic [7:0]                         data_o
);

    localparam int ADDR_W = $clog2(NUM_CONTROLLERS) + 3;
    localparam int BIT_W  = (BUTTONS > 1) ? $clog2(BUTTONS) : 1;

    logic             sample;
    logic [BIT_W-1:0] sample_idx;
    logic             commit;

    controller_hub_timing #(
        .BUTTONS           (BUTTONS),
        .LATCH_PULSE_WIDTH (LATCH_PULSE_WIDTH),
        .CLK_DIV           (CLK_DIV)
    ) u_timing (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_fetch (start_fetch_i),
        .busy        (busy_o),
        .valid       (valid_o),
        .pad_clk     (controller_clk_o),
        .pad_latch   (controller_latch_o),
        .sample      (sample),
        .sample_idx  (sample_idx)
    );

    // The commit cycle is exactly the cycle valid_o is high.
    assign commit = valid_o;

    controller_buttons_t shift_q   [NUM_CONTROLLERS];
    controller_buttons_t state_q   [NUM_CONTROLLERS];
    controller_buttons_t pressed_q [NUM_CONTROLLERS];
    controller_buttons_t clr_pressed [NUM_CONTROLLERS];
`ifdef CONTROLLER_HUB_RELEASED_EN
    controller_buttons_t released_q  [NUM_CONTROLLERS];
    controller_buttons_t clr_released [NUM_CONTROLLERS];
`endif

    logic [ADDR_W-1:0] pad_sel;
    logic [2:0]        reg_sel;
    logic              pad_ok;
    logic              rd_hit;

    assign pad_sel = addr_i >> $clog2(CONTROLLER_REG_STRIDE);
    assign reg_sel = addr_i[2:0];
    assign pad_ok  = (pad_sel < ADDR_W'(NUM_CONTROLLERS));
    assign rd_hit  = sel_i & rd_i & pad_ok;

    // Read-clear masks: one byte of the addressed pad's sticky register.
    always_comb begin
        for (int k = 0; k < NUM_CONTROLLERS; k++) begin
            clr_pressed[k] = '0;
`ifdef CONTROLLER_HUB_RELEASED_EN
            clr_released[k] = '0;
`endif
            if (rd_hit && pad_sel == ADDR_W'(k)) begin
                if (reg_sel == PRESSED_LO) clr_pressed[k] = 16'h00FF;
                if (reg_sel == PRESSED_HI) clr_pressed[k] = 16'hFF00;
`ifdef CONTROLLER_HUB_RELEASED_EN
                if (reg_sel == RELEASED_LO) clr_released[k] = 16'h00FF;
                if (reg_sel == RELEASED_HI) clr_released[k] = 16'hFF00;
`endif
            end
        end
    end

    // Capture one inverted pad bit per sample strobe into each shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CONTROLLERS; k++) shift_q[k] <= '0;
        end else if (sample) begin
            for (int k = 0; k < NUM_CONTROLLERS; k++)
                shift_q[k][sample_idx] <= ~controller_serial_ni[k];
        end
    end

    // Commit live state and edge bits; new edges are ORed after the clear so set wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CONTROLLERS; k++) begin
                state_q[k]   <= '0;
                pressed_q[k] <= '0;
`ifdef CONTROLLER_HUB_RELEASED_EN
                released_q[k] <= '0;
`endif
            end
        end else begin
            for (int k = 0; k < NUM_CONTROLLERS; k++) begin
                if (commit) begin
                    state_q[k]   <= shift_q[k];
                    pressed_q[k] <= (pressed_q[k] & ~clr_pressed[k]) | (shift_q[k] & ~state_q[k]);
`ifdef CONTROLLER_HUB_RELEASED_EN
                    released_q[k] <= (released_q[k] & ~clr_released[k]) | (state_q[k] & ~shift_q[k]);
`endif
                end else begin
                    pressed_q[k] <= pressed_q[k] & ~clr_pressed[k];
`ifdef CONTROLLER_HUB_RELEASED_EN
                    released_q[k] <= released_q[k] & ~clr_released[k];
`endif
                end
            end
        end
    end

    // Combinational read mux; unmapped pads and reserved regs return 0x00.
    always_comb begin
        data_o = 8'h00;
        for (int k = 0; k < NUM_CONTROLLERS; k++) begin
            if (pad_ok && pad_sel == ADDR_W'(k)) begin
                case (reg_sel)
                    STATE_LO:    data_o = state_q[k][7:0];
                    STATE_HI:    data_o = state_q[k][15:8];
                    PRESSED_LO:  data_o = pressed_q[k][7:0];
                    PRESSED_HI:  data_o = pressed_q[k][15:8];
`ifdef CONTROLLER_HUB_RELEASED_EN
                    RELEASED_LO: data_o = released_q[k][7:0];
                    RELEASED_HI: data_o = released_q[k][15:8];
`endif
                    default:     data_o = 8'h00;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_controller_hub.sv
// Scoreboard bench for controller_hub: stimulus pushes expected read data and
// expected valid_o cycles; a negedge monitor pops and compares.
module tb_controller_hub;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Main DUT: 2 pads x 8 buttons
    logic       start, busy, valid, pclk, plat, sel, rd;
    logic [1:0] ser_n;
    logic [3:0] addr;
    logic [7:0] data;

    // Second DUT: 1 pad x 12 buttons
    logic       start12, busy12, valid12, pclk12, plat12, sel12, rd12;
    logic [0:0] ser12_n;
    logic [2:0] addr12;
    logic [7:0] data12;

    controller_hub #(
        .NUM_CONTROLLERS(2), .BUTTONS(8), .LATCH_PULSE_WIDTH(2), .CLK_DIV(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_fetch_i(start), .busy_o(busy), .valid_o(valid),
        .controller_clk_o(pclk), .controller_latch_o(plat), .controller_serial_ni(ser_n),
        .sel_i(sel), .rd_i(rd), .addr_i(addr), .data_o(data)
    );

    controller_hub #(
        .NUM_CONTROLLERS(1), .BUTTONS(12), .LATCH_PULSE_WIDTH(2), .CLK_DIV(4)
    ) dut12 (
        .clk(clk), .rst_n(rst_n), .start_fetch_i(start12), .busy_o(busy12), .valid_o(valid12),
        .controller_clk_o(pclk12), .controller_latch_o(plat12), .controller_serial_ni(ser12_n),
        .sel_i(sel12), .rd_i(rd12), .addr_i(addr12), .data_o(data12)
    );

    // Pad models: parallel load while latch high, shift on shift-clock rise.
    logic [15:0] pad_btn [2] = '{default: 16'h0};
    logic [15:0] pad_sh  [2] = '{default: 16'h0};
    logic [15:0] pad12_btn = 16'h0;
    logic [15:0] pad12_sh  = 16'h0;
    logic        pclk_q = 1'b1;
    logic        pclk12_q = 1'b1;

    always @(posedge clk) begin
        pclk_q   <= pclk;
        pclk12_q <= pclk12;
        for (int k = 0; k < 2; k++) begin
            if (plat) pad_sh[k] <= pad_btn[k];
            else if (pclk && !pclk_q) pad_sh[k] <= pad_sh[k] >> 1;
        end
        if (plat12) pad12_sh <= pad12_btn;
        else if (pclk12 && !pclk12_q) pad12_sh <= pad12_sh >> 1;
    end

    always_comb begin
        ser_n[0]   = ~pad_sh[0][0];
        ser_n[1]   = ~pad_sh[1][0];
        ser12_n[0] = ~pad12_sh[0];
    end

    // Scoreboard
    typedef struct {
        string name;
        int    exp;
    } exp_t;

    exp_t qr[$];
    int   qv[$];
    int   qv12[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   cyc     = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: reads and valid pulses of both DUTs.
    always @(negedge clk) begin
        exp_t e;
        if (sel && rd) begin
            if (qr.size() == 0) chk("read_unexpected", 1, 0);
            else begin
                e = qr.pop_front();
                chk(e.name, int'(data), e.exp);
            end
        end
        if (sel12 && rd12) begin
            if (qr.size() == 0) chk("read12_unexpected", 1, 0);
            else begin
                e = qr.pop_front();
                chk(e.name, int'(data12), e.exp);
            end
        end
        if (valid) begin
            if (qv.size() == 0) chk("valid_unexpected", 1, 0);
            else chk("valid_latency", cyc, qv.pop_front());
        end
        if (valid12) begin
            if (qv12.size() == 0) chk("valid12_unexpected", 1, 0);
            else chk("valid12_latency", cyc, qv12.pop_front());
        end
    end

    task automatic rd_main(input int a, input int exp, input string name);
        @(posedge clk); #1;
        sel = 1'b1; rd = 1'b1; addr = 4'(a);
        qr.push_back('{name, exp});
        @(posedge clk); #1;
        sel = 1'b0; rd = 1'b0;
    endtask

    task automatic rd_12(input int a, input int exp, input string name);
        @(posedge clk); #1;
        sel12 = 1'b1; rd12 = 1'b1; addr12 = 3'(a);
        qr.push_back('{name, exp});
        @(posedge clk); #1;
        sel12 = 1'b0; rd12 = 1'b0;
    endtask

    // Full scan of the main DUT; optionally pokes start mid-scan (must be ignored).
    task automatic scan_main(input int p0, input int p1, input bit extra_start);
        int used;
        pad_btn[0] = 16'(p0);
        pad_btn[1] = 16'(p1);
        @(posedge clk); #1;
        start = 1'b1;
        qv.push_back(cyc + 67);
        @(posedge clk); #1;
        start = 1'b0;
        used = 1;
        if (extra_start) begin
            repeat (19) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            used = 21;
        end
        repeat (70 - used) @(posedge clk);
    endtask

    initial begin
        start = 0; sel = 0; rd = 0; addr = '0;
        start12 = 0; sel12 = 0; rd12 = 0; addr12 = '0;

        repeat (3) @(posedge clk);
        #2;
        chk("reset_latch", int'(plat), 0);
        chk("reset_clk", int'(pclk), 1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_valid", int'(valid), 0);
        rst_n = 1'b1;

        rd_main(0, 'h00, "reset_state_lo");
        rd_main(2, 'h00, "reset_pressed_lo");
        rd_main(8, 'h00, "reset_pad1_state");

        // Scan 1: pad0 A+Start, pad1 idle; extra start mid-scan is ignored.
        scan_main('h09, 'h00, 1'b1);
        rd_main(0, 'h09, "s1_state_lo");
        rd_main(1, 'h00, "s1_state_hi");
        rd_main(2, 'h09, "s1_pressed_lo");
        rd_main(3, 'h00, "s1_pressed_hi");
        rd_main(8, 'h00, "s1_pad1_state");
        rd_main(10, 'h00, "s1_pad1_pressed");
        rd_main(4, 'h00, "s1_reg4");
        rd_main(5, 'h00, "s1_reg5");
        rd_main(6, 'h00, "s1_reg6");
        rd_main(7, 'h00, "s1_reg7");
        rd_main(2, 'h00, "s1_pressed_cleared");

        // Scan 2: same input, no new presses.
        scan_main('h09, 'h00, 1'b0);
        rd_main(2, 'h00, "s2_pressed_lo");
        rd_main(0, 'h09, "s2_state_lo");

        // Scan 3: Start released.
        scan_main('h01, 'h00, 1'b0);
        rd_main(0, 'h01, "s3_state_lo");
        rd_main(2, 'h00, "s3_pressed_lo");
`ifdef CONTROLLER_HUB_RELEASED_EN
        rd_main(4, 'h08, "s3_released_lo");
        rd_main(4, 'h00, "s3_released_cleared");
        rd_main(5, 'h00, "s3_released_hi");
`else
        rd_main(4, 'h00, "s3_reg4_reserved");
        rd_main(5, 'h00, "s3_reg5_reserved");
`endif

        // Scan 4: Start pressed again -> PRESSED 0x08, left unread.
        scan_main('h09, 'h00, 1'b0);

        // Scan 5: press bit 4 while reading PRESSED_LO during COMMIT.
        pad_btn[0] = 16'h19;
        @(posedge clk); #1;
        start = 1'b1;
        qv.push_back(cyc + 67);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (66) @(posedge clk);
        #1;
        sel = 1'b1; rd = 1'b1; addr = 4'd2;
        qr.push_back('{"s5_read_during_commit", 'h08});
        @(posedge clk); #1;
        sel = 1'b0; rd = 1'b0;
        repeat (2) @(posedge clk);
        rd_main(2, 'h10, "s5_set_wins");
        rd_main(0, 'h19, "s5_state_lo");

        // 12-button pad, all pressed.
        pad12_btn = 16'h0FFF;
        @(posedge clk); #1;
        start12 = 1'b1;
        qv12.push_back(cyc + 99);
        @(posedge clk); #1;
        start12 = 1'b0;
        repeat (102) @(posedge clk);
        rd_12(0, 'hFF, "b12_state_lo");
        rd_12(1, 'h0F, "b12_state_hi");
        rd_12(3, 'h0F, "b12_pressed_hi");
        rd_12(2, 'hFF, "b12_pressed_lo");
        rd_12(4, 'h00, "b12_reg4");
        rd_12(5, 'h00, "b12_reg5");
        rd_12(6, 'h00, "b12_reg6");
        rd_12(7, 'h00, "b12_reg7");

        // Reset during HIGH of bit 3.
        pad_btn[0] = 16'h09;
        pad_btn[1] = 16'h03;
        @(posedge clk); #1;
        start = 1'b1;
        qv.push_back(cyc + 67);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (31) @(posedge clk);
        #2;
        chk("mid_scan_clk_high", int'(pclk), 1);
        chk("mid_scan_busy", int'(busy), 1);
        rst_n = 1'b0;
        qv.delete();
        #1;
        chk("midrst_latch", int'(plat), 0);
        chk("midrst_clk", int'(pclk), 1);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_valid", int'(valid), 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        rd_main(0, 'h00, "midrst_state_lo");
        rd_main(2, 'h00, "midrst_pressed_lo");
        rd_main(8, 'h00, "midrst_pad1_state");
        rd_12(0, 'h00, "midrst_b12_state_lo");
        repeat (80) @(posedge clk);

        chk("valid_queue_drained", qv.size(), 0);
        chk("valid12_queue_drained", qv12.size(), 0);
        chk("read_queue_drained", qr.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
